// File: rtl/mem_wb_pipe_stage.sv
// MEM->WB pipeline stage.
// Holds one head entry (plus one skid entry when SKID=1) between the data-memory
// stage and the register-file write port. Transfers use a valid/ready handshake.
// A flush discards everything held and anything offered in the same cycle.
// The writeback mux and the commit strobe are decoded from the head register.
module mem_wb_pipe_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_wreg,
    input  logic              in_m2reg,
    input  logic [DATA_W-1:0] in_alu_data,
    input  logic [DATA_W-1:0] in_mem_data,
    input  logic [ADDR_W-1:0] in_reg_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_wreg,
    output logic              out_m2reg,
    output logic [DATA_W-1:0] out_alu_data,
    output logic [DATA_W-1:0] out_mem_data,
    output logic [ADDR_W-1:0] out_reg_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_we
);

    // Occupancy: EMPTY = nothing held, HALF = head only, FULL = head + skid.
    // FULL is unreachable when SKID=0 because in_ready then requires a drain.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HALF  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic              wreg;
        logic              m2reg;
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] mem;
        logic [ADDR_W-1:0] addr;
    } entry_t;

    state_t r_state;
    entry_t r_main;
    entry_t r_skid;

    entry_t w_in;
    logic   w_in_ready;
    logic   w_out_valid;
    logic   w_acc;
    logic   w_drn;

    assign w_in        = {in_wreg, in_m2reg, in_alu_data, in_mem_data, in_reg_addr};
    assign w_out_valid = (r_state != ST_EMPTY);

    // Ready decision: registered-only with a skid slot, otherwise a pass-through
    // of downstream readiness so the single register can be replaced in place.
    generate
        if (SKID != 0) begin : g_skid
            assign w_in_ready = ~rst & (r_state != ST_FULL);
        end else begin : g_noskid
            assign w_in_ready = ~rst & (out_ready | ~w_out_valid);
        end
    endgenerate

    assign w_acc = in_valid & w_in_ready;
    assign w_drn = w_out_valid & out_ready;

    // Occupancy FSM and payload registers; reset clears the visible head fields,
    // flush only drops the valid state and leaves payload as don't-care.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_EMPTY;
            r_main  <= '0;
            r_skid  <= '0;
        end else if (flush) begin
            r_state <= ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_acc) begin
                        r_main  <= w_in;
                        r_state <= ST_HALF;
                    end
                end
                ST_HALF: begin
                    if (w_acc && w_drn) begin
                        r_main <= w_in;
                    end else if (w_acc) begin
                        r_skid  <= w_in;
                        r_state <= ST_FULL;
                    end else if (w_drn) begin
                        r_state <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_drn) begin
                        r_main  <= r_skid;
                        r_state <= ST_HALF;
                    end
                end
                default: begin
                    r_state <= ST_EMPTY;
                end
            endcase
        end
    end

    assign in_ready     = w_in_ready;
    assign out_valid    = w_out_valid;
    assign out_wreg     = r_main.wreg;
    assign out_m2reg    = r_main.m2reg;
    assign out_alu_data = r_main.alu;
    assign out_mem_data = r_main.mem;
    assign out_reg_addr = r_main.addr;

    // Writeback select and commit strobe; register 0 is never written and a
    // flush or reset cycle never commits.
    assign wb_data = r_main.m2reg ? r_main.mem : r_main.alu;
    assign wb_we   = w_drn & r_main.wreg & (|r_main.addr) & ~flush & ~rst;

endmodule

// File: tb/tb_mem_wb_pipe_stage.sv
// Directed bench for mem_wb_pipe_stage: a table of per-cycle vectors on the
// SKID=1 instance, plus hand sequences for reset-in-FULL and the SKID=0 variant.
module tb_mem_wb_pipe_stage;

    localparam int DW = 32;
    localparam int AW = 5;

    logic clk = 1'b0;
    logic rst;

    // SKID=1 instance signals
    logic          s1_flush, s1_in_valid, s1_in_ready, s1_in_wreg, s1_in_m2reg;
    logic [DW-1:0] s1_in_alu, s1_in_mem;
    logic [AW-1:0] s1_in_addr;
    logic          s1_out_valid, s1_out_ready, s1_out_wreg, s1_out_m2reg;
    logic [DW-1:0] s1_out_alu, s1_out_mem, s1_wb_data;
    logic [AW-1:0] s1_out_addr;
    logic          s1_wb_we;

    // SKID=0 instance signals
    logic          s0_flush, s0_in_valid, s0_in_ready, s0_in_wreg, s0_in_m2reg;
    logic [DW-1:0] s0_in_alu, s0_in_mem;
    logic [AW-1:0] s0_in_addr;
    logic          s0_out_valid, s0_out_ready, s0_out_wreg, s0_out_m2reg;
    logic [DW-1:0] s0_out_alu, s0_out_mem, s0_wb_data;
    logic [AW-1:0] s0_out_addr;
    logic          s0_wb_we;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mem_wb_pipe_stage #(.DATA_W(DW), .ADDR_W(AW), .SKID(1)) dut (
        .clk(clk), .rst(rst), .flush(s1_flush),
        .in_valid(s1_in_valid), .in_ready(s1_in_ready),
        .in_wreg(s1_in_wreg), .in_m2reg(s1_in_m2reg),
        .in_alu_data(s1_in_alu), .in_mem_data(s1_in_mem), .in_reg_addr(s1_in_addr),
        .out_valid(s1_out_valid), .out_ready(s1_out_ready),
        .out_wreg(s1_out_wreg), .out_m2reg(s1_out_m2reg),
        .out_alu_data(s1_out_alu), .out_mem_data(s1_out_mem), .out_reg_addr(s1_out_addr),
        .wb_data(s1_wb_data), .wb_we(s1_wb_we)
    );

    mem_wb_pipe_stage #(.DATA_W(DW), .ADDR_W(AW), .SKID(0)) dut0 (
        .clk(clk), .rst(rst), .flush(s0_flush),
        .in_valid(s0_in_valid), .in_ready(s0_in_ready),
        .in_wreg(s0_in_wreg), .in_m2reg(s0_in_m2reg),
        .in_alu_data(s0_in_alu), .in_mem_data(s0_in_mem), .in_reg_addr(s0_in_addr),
        .out_valid(s0_out_valid), .out_ready(s0_out_ready),
        .out_wreg(s0_out_wreg), .out_m2reg(s0_out_m2reg),
        .out_alu_data(s0_out_alu), .out_mem_data(s0_out_mem), .out_reg_addr(s0_out_addr),
        .wb_data(s0_wb_data), .wb_we(s0_wb_we)
    );

    // One cycle of stimulus and the outputs expected during that cycle.
    typedef struct {
        logic          iv;
        logic          ordy;
        logic          fl;
        logic          wreg;
        logic          m2;
        logic [DW-1:0] alu;
        logic [DW-1:0] mem;
        logic [AW-1:0] addr;
        logic          chk_pay;
        logic          e_ov;
        logic          e_ir;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wbd;
        logic          e_we;
    } vec_t;

    localparam int NV = 26;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic iv, input logic ordy, input logic fl,
                                input logic wreg, input logic m2,
                                input logic [DW-1:0] alu, input logic [DW-1:0] mem,
                                input logic [AW-1:0] addr, input logic chk_pay,
                                input logic e_ov, input logic e_ir,
                                input logic [AW-1:0] e_addr, input logic [DW-1:0] e_wbd,
                                input logic e_we);
        vec_t v;
        v.iv = iv; v.ordy = ordy; v.fl = fl; v.wreg = wreg; v.m2 = m2;
        v.alu = alu; v.mem = mem; v.addr = addr; v.chk_pay = chk_pay;
        v.e_ov = e_ov; v.e_ir = e_ir; v.e_addr = e_addr; v.e_wbd = e_wbd; v.e_we = e_we;
        return v;
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic s1_drive(input logic iv, input logic ordy, input logic fl,
                            input logic wreg, input logic m2, input logic [DW-1:0] alu,
                            input logic [DW-1:0] mem, input logic [AW-1:0] addr);
        s1_in_valid = iv; s1_out_ready = ordy; s1_flush = fl; s1_in_wreg = wreg;
        s1_in_m2reg = m2; s1_in_alu = alu; s1_in_mem = mem; s1_in_addr = addr;
    endtask

    task automatic s0_drive(input logic iv, input logic ordy,
                            input logic [DW-1:0] alu, input logic [AW-1:0] addr);
        s0_in_valid = iv; s0_out_ready = ordy; s0_flush = 1'b0; s0_in_wreg = 1'b1;
        s0_in_m2reg = 1'b0; s0_in_alu = alu; s0_in_mem = 32'h0BAD_0000; s0_in_addr = addr;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Columns: iv ordy fl wreg m2 alu mem addr chk | ov ir addr wb_data we
        // Streaming, 4 entries back to back
        vecs[0]  = mk(1,1,0,1,0,32'h10,32'h0BAD0001,5'd1, 1, 0,1,5'd0, 32'h00,0);
        vecs[1]  = mk(1,1,0,1,0,32'h20,32'h0BAD0002,5'd2, 1, 1,1,5'd1, 32'h10,1);
        vecs[2]  = mk(1,1,0,1,0,32'h30,32'h0BAD0003,5'd3, 1, 1,1,5'd2, 32'h20,1);
        vecs[3]  = mk(1,1,0,1,0,32'h40,32'h0BAD0004,5'd4, 1, 1,1,5'd3, 32'h30,1);
        vecs[4]  = mk(0,1,0,1,0,32'h0, 32'h0,       5'd0, 1, 1,1,5'd4, 32'h40,1);
        vecs[5]  = mk(0,1,0,1,0,32'h0, 32'h0,       5'd0, 1, 0,1,5'd4, 32'h40,0);
        // Back-pressure into FULL, then drain A then B
        vecs[6]  = mk(1,0,0,1,0,32'h50,32'h0BAD0005,5'd5, 1, 0,1,5'd4, 32'h40,0);
        vecs[7]  = mk(1,0,0,1,0,32'h60,32'h0BAD0006,5'd6, 1, 1,1,5'd5, 32'h50,0);
        vecs[8]  = mk(1,0,0,1,0,32'h90,32'h0BAD0009,5'd9, 1, 1,0,5'd5, 32'h50,0);
        vecs[9]  = mk(0,1,0,1,0,32'h0, 32'h0,       5'd0, 1, 1,0,5'd5, 32'h50,1);
        vecs[10] = mk(0,1,0,1,0,32'h0, 32'h0,       5'd0, 1, 1,1,5'd6, 32'h60,1);
        vecs[11] = mk(0,1,0,1,0,32'h0, 32'h0,       5'd0, 1, 0,1,5'd6, 32'h60,0);
        // Load-data mux and register-0 suppression
        vecs[12] = mk(1,1,0,1,1,32'h1, 32'hDEADBEEF,5'd0, 1, 0,1,5'd6, 32'h60,0);
        vecs[13] = mk(1,1,0,1,1,32'h1, 32'hDEADBEEF,5'd7, 1, 1,1,5'd0, 32'hDEADBEEF,0);
        vecs[14] = mk(0,1,0,1,0,32'h0, 32'h0,       5'd0, 1, 1,1,5'd7, 32'hDEADBEEF,1);
        vecs[15] = mk(0,1,0,1,0,32'h0, 32'h0,       5'd0, 1, 0,1,5'd7, 32'hDEADBEEF,0);
        // Flush in FULL with an incoming entry, then flush with acceptance in EMPTY
        vecs[16] = mk(1,0,0,1,0,32'hA0,32'h0BAD000A,5'd10,1, 0,1,5'd7, 32'hDEADBEEF,0);
        vecs[17] = mk(1,0,0,1,0,32'hB0,32'h0BAD000B,5'd11,1, 1,1,5'd10,32'hA0,0);
        vecs[18] = mk(1,1,1,1,0,32'hC0,32'h0BAD000C,5'd12,1, 1,0,5'd10,32'hA0,0);
        vecs[19] = mk(1,0,1,1,0,32'hD0,32'h0BAD000D,5'd13,0, 0,1,5'd0, 32'h0, 0);
        vecs[20] = mk(0,1,0,1,0,32'h0, 32'h0,       5'd0, 0, 0,1,5'd0, 32'h0, 0);
        vecs[21] = mk(1,1,0,1,0,32'hE0,32'h0BAD000E,5'd14,0, 0,1,5'd0, 32'h0, 0);
        vecs[22] = mk(0,1,0,1,0,32'h0, 32'h0,       5'd0, 1, 1,1,5'd14,32'hE0,1);
        // Non-writing entry still retires but never commits
        vecs[23] = mk(1,1,0,0,0,32'hF0,32'h0BAD000F,5'd15,1, 0,1,5'd14,32'hE0,0);
        vecs[24] = mk(0,1,0,1,0,32'h0, 32'h0,       5'd0, 1, 1,1,5'd15,32'hF0,0);
        vecs[25] = mk(0,1,0,1,0,32'h0, 32'h0,       5'd0, 1, 0,1,5'd15,32'hF0,0);

        // Reset: two cycles with in_valid high on both instances
        rst = 1'b1;
        s1_drive(1, 1, 0, 1, 0, 32'h77, 32'h88, 5'd3);
        s0_drive(1, 1, 32'h77, 5'd3);
        @(negedge clk); #1;
        check("rst_in_ready_c1", {31'd0, s1_in_ready}, 32'd0);
        @(negedge clk); #1;
        check("rst_in_ready_c2", {31'd0, s1_in_ready}, 32'd0);
        check("rst_out_valid",   {31'd0, s1_out_valid}, 32'd0);
        check("rst_out_addr",    {27'd0, s1_out_addr}, 32'd0);
        check("rst_wb_data",     s1_wb_data, 32'd0);
        check("rst_s0_in_ready", {31'd0, s0_in_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        s1_drive(0, 1, 0, 0, 0, 32'h0, 32'h0, 5'd0);
        s0_drive(0, 1, 32'h0, 5'd0);
        #1;
        check("rst_release_in_ready", {31'd0, s1_in_ready}, 32'd1);
        check("rst_release_out_valid", {31'd0, s1_out_valid}, 32'd0);
        $display("reset sequence done");

        // Table-driven per-cycle vectors on the SKID=1 instance
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            s1_drive(vecs[i].iv, vecs[i].ordy, vecs[i].fl, vecs[i].wreg, vecs[i].m2,
                     vecs[i].alu, vecs[i].mem, vecs[i].addr);
            #1;
            $display("vec %0d: iv=%0b ordy=%0b fl=%0b addr=%0d -> ov=%0b ir=%0b oaddr=%0d wbd=0x%08h we=%0b",
                     i, vecs[i].iv, vecs[i].ordy, vecs[i].fl, vecs[i].addr,
                     s1_out_valid, s1_in_ready, s1_out_addr, s1_wb_data, s1_wb_we);
            check($sformatf("vec%0d_out_valid", i), {31'd0, s1_out_valid}, {31'd0, vecs[i].e_ov});
            check($sformatf("vec%0d_in_ready", i),  {31'd0, s1_in_ready},  {31'd0, vecs[i].e_ir});
            check($sformatf("vec%0d_wb_we", i),     {31'd0, s1_wb_we},     {31'd0, vecs[i].e_we});
            if (vecs[i].chk_pay) begin
                check($sformatf("vec%0d_out_addr", i), {27'd0, s1_out_addr}, {27'd0, vecs[i].e_addr});
                check($sformatf("vec%0d_wb_data", i),  s1_wb_data, vecs[i].e_wbd);
            end
        end

        // Reset while FULL: both entries discarded, head fields cleared
        @(negedge clk);
        s1_drive(1, 0, 0, 1, 1, 32'h160, 32'h1600, 5'd16);
        @(negedge clk);
        s1_drive(1, 0, 0, 1, 0, 32'h170, 32'h1700, 5'd17);
        @(negedge clk);
        rst = 1'b1;
        s1_drive(1, 1, 0, 1, 0, 32'h180, 32'h1800, 5'd18);
        #1;
        check("rstfull_in_ready", {31'd0, s1_in_ready}, 32'd0);
        check("rstfull_out_valid_pre", {31'd0, s1_out_valid}, 32'd1);
        check("rstfull_wb_we", {31'd0, s1_wb_we}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        s1_drive(0, 1, 0, 0, 0, 32'h0, 32'h0, 5'd0);
        #1;
        check("rstfull_out_valid", {31'd0, s1_out_valid}, 32'd0);
        check("rstfull_out_addr", {27'd0, s1_out_addr}, 32'd0);
        check("rstfull_out_alu", s1_out_alu, 32'd0);
        check("rstfull_out_mem", s1_out_mem, 32'd0);
        check("rstfull_out_flags", {30'd0, s1_out_wreg, s1_out_m2reg}, 32'd0);
        check("rstfull_wb_data", s1_wb_data, 32'd0);
        check("rstfull_in_ready_after", {31'd0, s1_in_ready}, 32'd1);
        @(negedge clk); #1;
        check("rstfull_nothing_retires", {31'd0, s1_out_valid}, 32'd0);
        $display("reset-in-full sequence done");

        // SKID=0: ready follows out_ready combinationally while head is valid
        @(negedge clk);
        s0_drive(1, 0, 32'h33, 5'd3);
        #1;
        check("s0_empty_in_ready", {31'd0, s0_in_ready}, 32'd1);
        @(negedge clk);
        s0_drive(1, 0, 32'h44, 5'd4);
        #1;
        check("s0_held_out_valid", {31'd0, s0_out_valid}, 32'd1);
        check("s0_held_in_ready", {31'd0, s0_in_ready}, 32'd0);
        check("s0_held_wb_we", {31'd0, s0_wb_we}, 32'd0);
        @(negedge clk); #1;
        check("s0_still_head", {27'd0, s0_out_addr}, 32'd3);
        s0_out_ready = 1'b1;
        #1;
        check("s0_release_in_ready", {31'd0, s0_in_ready}, 32'd1);
        check("s0_release_wb_we", {31'd0, s0_wb_we}, 32'd1);
        check("s0_release_wb_data", s0_wb_data, 32'h33);
        @(negedge clk);
        s0_drive(0, 1, 32'h0, 5'd0);
        #1;
        check("s0_replaced_addr", {27'd0, s0_out_addr}, 32'd4);
        check("s0_replaced_wb_data", s0_wb_data, 32'h44);
        check("s0_replaced_valid", {31'd0, s0_out_valid}, 32'd1);
        @(negedge clk); #1;
        check("s0_drained_valid", {31'd0, s0_out_valid}, 32'd0);
        $display("skid0 sequence done");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
